// File: rtl/cfg_pkg.sv
// rtl/cfg_pkg.sv - shared opcodes, default sync word and FSM encoding for the frame writer
package cfg_pkg;

    localparam logic [7:0]  OP_NOP   = 8'h00;
    localparam logic [7:0]  OP_WRITE = 8'h01;
    localparam logic [7:0]  OP_END   = 8'h02;

    localparam logic [31:0] SYNC_WORD_DEFAULT = 32'hFAB0FAB1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HDR    = 2'd1,
        ST_DATA   = 2'd2,
        ST_STROBE = 2'd3
    } cfg_state_t;

endpackage

// File: rtl/cfg_frame_writer_if.sv
// rtl/cfg_frame_writer_if.sv - configuration word stream handshake
interface cfg_frame_writer_if #(
    parameter int W = 32
);
    logic [W-1:0] s_data;
    logic         s_valid;
    logic         s_ready;

    modport master (output s_data, output s_valid, input s_ready);
    modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/cfg_strobe_decoder.sv
// rtl/cfg_strobe_decoder.sv - registered one-hot decode of column/frame into FrameStrobe
module cfg_strobe_decoder #(
    parameter int NumberOfCols    = 16,
    parameter int MaxFramesPerCol = 20,
    parameter int CW              = 4,
    parameter int FW              = 5
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [CW-1:0]                         col,
    input  logic [FW-1:0]                         frame,
    input  logic                                  en,
    output logic [NumberOfCols*MaxFramesPerCol-1:0] strobe
);

    logic [NumberOfCols*MaxFramesPerCol-1:0] strobe_d;

    // At most one bit can match, so the strobe is one-hot or zero by construction.
    always_comb begin
        strobe_d = '0;
        for (int i = 0; i < NumberOfCols*MaxFramesPerCol; i++) begin
            if (en && (i == int'(col) * MaxFramesPerCol + int'(frame))) begin
                strobe_d[i] = 1'b1;
            end
        end
    end

    // Registered so the strobe lines up with the single STROBE state cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            strobe <= '0;
        end else begin
            strobe <= strobe_d;
        end
    end

endmodule

// File: rtl/cfg_frame_writer.sv
// rtl/cfg_frame_writer.sv - parses sync/header/row stream, assembles a frame, pulses one strobe
module cfg_frame_writer
    import cfg_pkg::*;
#(
    parameter int          NumberOfRows    = 16,
    parameter int          NumberOfCols    = 16,
    parameter int          MaxFramesPerCol = 20,
    parameter int          FrameBitsPerRow = 32,
    parameter logic [31:0] SyncWord        = SYNC_WORD_DEFAULT
) (
    input  logic                                    UserCLK,
    input  logic                                    Reset,
    cfg_frame_writer_if.slave                       s,
    output logic [NumberOfRows*FrameBitsPerRow-1:0] FrameData,
    output logic [NumberOfCols*MaxFramesPerCol-1:0] FrameStrobe,
    output logic                                    busy,
    output logic                                    done,
    output logic                                    error
);

    localparam int RW = $clog2(NumberOfRows);
    localparam int CW = $clog2(NumberOfCols);
    localparam int FW = $clog2(MaxFramesPerCol);

    cfg_state_t state_q, state_d;

    logic [FrameBitsPerRow-1:0] rows_q [NumberOfRows];
    logic [RW-1:0]              row_q;
    logic [CW-1:0]              col_q;
    logic [FW-1:0]              frame_q;
    logic                       discard_q;
    logic                       done_q;
    logic                       error_q;

    logic                       xfer;
    logic                       last_row;
    logic [7:0]                 hdr_op;
    logic [7:0]                 hdr_col;
    logic [15:0]                hdr_frame;
    logic                       hdr_in_range;

    logic                       strobe_en;
    logic                       set_error;
    logic                       clr_error;
    logic                       start_frame;
    logic                       end_seen;

    assign s.s_ready    = (state_q != ST_STROBE);
    assign xfer         = s.s_valid && s.s_ready;
    assign last_row     = (row_q == RW'(NumberOfRows - 1));
    assign hdr_op       = s.s_data[31:24];
    assign hdr_col      = s.s_data[23:16];
    assign hdr_frame    = s.s_data[15:0];
    assign hdr_in_range = ({24'd0, hdr_col} < NumberOfCols) &&
                          ({16'd0, hdr_frame} < MaxFramesPerCol);

    assign busy  = (state_q != ST_IDLE);
    assign done  = done_q;
    assign error = error_q;

    genvar gr;
    generate
        for (gr = 0; gr < NumberOfRows; gr++) begin : g_rows
            assign FrameData[gr*FrameBitsPerRow +: FrameBitsPerRow] = rows_q[gr];
        end
    endgenerate

    // Next-state decode; outside IDLE a sync word is just another header or data word.
    always_comb begin
        state_d     = state_q;
        strobe_en   = 1'b0;
        set_error   = 1'b0;
        clr_error   = 1'b0;
        start_frame = 1'b0;
        end_seen    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (xfer && (s.s_data == SyncWord)) begin
                    state_d   = ST_HDR;
                    clr_error = 1'b1;
                end
            end
            ST_HDR: begin
                if (xfer) begin
                    case (hdr_op)
                        OP_WRITE: begin
                            state_d     = ST_DATA;
                            start_frame = 1'b1;
                            set_error   = !hdr_in_range;
                        end
                        OP_END: begin
                            state_d  = ST_IDLE;
                            end_seen = 1'b1;
                        end
                        OP_NOP: begin
                            state_d = ST_HDR;
                        end
                        default: begin
                            set_error = 1'b1;
                        end
                    endcase
                end
            end
            ST_DATA: begin
                if (xfer && last_row) begin
                    state_d   = discard_q ? ST_HDR : ST_STROBE;
                    strobe_en = !discard_q;
                end
            end
            ST_STROBE: begin
                state_d = ST_HDR;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register; reset drops any partial frame.
    always_ff @(posedge UserCLK or posedge Reset) begin
        if (Reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Frame rows, row counter, latched address and status flags.
    always_ff @(posedge UserCLK or posedge Reset) begin
        if (Reset) begin
            for (int r = 0; r < NumberOfRows; r++) begin
                rows_q[r] <= '0;
            end
            row_q     <= '0;
            col_q     <= '0;
            frame_q   <= '0;
            discard_q <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            done_q <= end_seen;
            if (clr_error) begin
                error_q <= 1'b0;
            end else if (set_error) begin
                error_q <= 1'b1;
            end
            if (start_frame) begin
                col_q     <= hdr_col[CW-1:0];
                frame_q   <= hdr_frame[FW-1:0];
                discard_q <= !hdr_in_range;
                row_q     <= '0;
            end
            if ((state_q == ST_DATA) && xfer) begin
                rows_q[row_q] <= s.s_data;
                row_q         <= last_row ? '0 : row_q + 1'b1;
            end
        end
    end

    cfg_strobe_decoder #(
        .NumberOfCols    (NumberOfCols),
        .MaxFramesPerCol (MaxFramesPerCol),
        .CW              (CW),
        .FW              (FW)
    ) u_strobe (
        .clk    (UserCLK),
        .rst    (Reset),
        .col    (col_q),
        .frame  (frame_q),
        .en     (strobe_en),
        .strobe (FrameStrobe)
    );

endmodule

// File: tb/tb_cfg_frame_writer.sv
// tb/tb_cfg_frame_writer.sv - directed scoreboard bench for cfg_frame_writer
module tb_cfg_frame_writer;

    localparam int ROWS = 16;
    localparam int COLS = 16;
    localparam int FPC  = 20;
    localparam int FB   = 32;
    localparam logic [31:0] SYNC = 32'hFAB0FAB1;

    logic UserCLK = 1'b0;
    logic Reset   = 1'b1;
    logic [ROWS*FB-1:0]  FrameData;
    logic [COLS*FPC-1:0] FrameStrobe;
    logic busy, done, error;

    cfg_frame_writer_if #(.W(FB)) sif ();

    cfg_frame_writer #(
        .NumberOfRows    (ROWS),
        .NumberOfCols    (COLS),
        .MaxFramesPerCol (FPC),
        .FrameBitsPerRow (FB),
        .SyncWord        (SYNC)
    ) dut (
        .UserCLK     (UserCLK),
        .Reset       (Reset),
        .s           (sif.slave),
        .FrameData   (FrameData),
        .FrameStrobe (FrameStrobe),
        .busy        (busy),
        .done        (done),
        .error       (error)
    );

    always #5 UserCLK = ~UserCLK;

    int n_checks = 0;
    int n_pass   = 0;
    int exp_q[$];
    int strobes_pushed = 0;
    int ready_low_cnt  = 0;
    logic [FB-1:0] exp_rows [ROWS];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Scoreboard side: every strobe cycle must match the oldest expected address and the row model.
    always @(negedge UserCLK) begin
        if (!Reset && !sif.s_ready) ready_low_cnt++;
        if (|FrameStrobe) begin
            check("strobe_pending", 64'(exp_q.size() > 0), 64'd1);
            check("strobe_onehot", 64'($countones(FrameStrobe)), 64'd1);
            check("strobe_ready_low", {62'd0, sif.s_ready, busy}, 64'b01);
            if (exp_q.size() > 0) begin
                automatic int idx = exp_q.pop_front();
                automatic int bad = 0;
                check("strobe_bit", 64'(FrameStrobe[idx]), 64'd1);
                for (int r = 0; r < ROWS; r++)
                    if (FrameData[r*FB +: FB] !== exp_rows[r]) bad++;
                check("strobe_rows_bad", 64'(bad), 64'd0);
            end
        end
    end

    // Called at a negedge; returns at the negedge following acceptance.
    task automatic send(input logic [31:0] w, input int gap);
        logic acc;
        acc = 1'b0;
        sif.s_valid = 1'b1;
        sif.s_data  = w;
        for (int t = 0; t < 50 && !acc; t++) begin
            acc = sif.s_ready;
            @(posedge UserCLK);
            @(negedge UserCLK);
        end
        if (!acc) check("send_timeout", 64'd0, 64'd1);
        if (gap > 0) begin
            sif.s_valid = 1'b0;
            repeat (gap) @(negedge UserCLK);
        end
    endtask

    task automatic write_frame(input int col, input int frm, input logic [31:0] base,
                               input int gap, input int nwords, input bit expect_strobe);
        send({8'h01, 8'(col), 16'(frm)}, gap);
        if (expect_strobe) begin
            exp_q.push_back(col*FPC + frm);
            strobes_pushed++;
        end
        for (int r = 0; r < nwords; r++) begin
            exp_rows[r] = base + 32'(r);
            send(base + 32'(r), gap);
        end
        sif.s_valid = 1'b0;
    endtask

    initial begin
        sif.s_valid = 1'b0;
        sif.s_data  = '0;
        for (int r = 0; r < ROWS; r++) exp_rows[r] = '0;
        repeat (3) @(negedge UserCLK);
        Reset = 1'b0;
        @(negedge UserCLK);
        check("rst_outputs", {61'd0, busy, done, error}, 64'd0);
        check("rst_data_strobe", 64'({|FrameData, |FrameStrobe}), 64'd0);
        check("rst_ready", 64'(sif.s_ready), 64'd1);

        // 1: basic frame, col 2 frame 5 -> bit 45, strobe the cycle after the last word
        send(SYNC, 0);
        check("sync_busy", 64'(busy), 64'd1);
        write_frame(2, 5, 32'h1000, 0, ROWS, 1'b1);
        check("t1_latency", 64'(FrameStrobe[45]), 64'd1);
        @(negedge UserCLK);
        check("t1_strobe_gone", 64'(|FrameStrobe), 64'd0);
        check("t1_row15_held", 64'(FrameData[15*FB +: FB]), 64'h100F);

        // 2: same frame with bubbles
        write_frame(2, 5, 32'h1000, 1, ROWS, 1'b1);
        repeat (3) @(negedge UserCLK);
        check("t2_queue_empty", 64'(exp_q.size()), 64'd0);

        // 3: out-of-range column, rows consumed but no strobe, error sticky
        write_frame(16, 0, 32'h3000, 0, ROWS, 1'b0);
        check("t3_error", 64'(error), 64'd1);
        check("t3_row3", 64'(FrameData[3*FB +: FB]), 64'h3003);
        write_frame(1, 0, 32'h3100, 0, ROWS, 1'b1);
        @(negedge UserCLK);
        check("t3_error_sticky", 64'(error), 64'd1);
        check("t3_queue_empty", 64'(exp_q.size()), 64'd0);

        // 4: END, junk in IDLE, resync clears error, END pulses done
        send({8'h02, 24'd0}, 0);
        check("t4a_done", {62'd0, done, busy}, 64'b10);
        send(32'h12345678, 0);
        send(32'hFAB0FAB0, 0);
        check("t4_idle_drop", {62'd0, busy, error}, 64'b01);
        send(SYNC, 0);
        check("t4_sync_clear", {62'd0, busy, error}, 64'b10);
        send({8'h02, 24'd0}, 0);
        sif.s_valid = 1'b0;
        check("t4_done_pulse", {61'd0, done, busy, error}, 64'b100);
        @(negedge UserCLK);
        check("t4_done_low", 64'(done), 64'd0);

        // 5: reset after 7 data words, then a clean frame col 3 frame 7
        send(SYNC, 0);
        write_frame(3, 7, 32'h5000, 0, 7, 1'b0);
        Reset = 1'b1;
        #1;
        check("t5_rst_outputs", {61'd0, busy, done, error}, 64'd0);
        check("t5_rst_data", 64'(|FrameData), 64'd0);
        for (int r = 0; r < ROWS; r++) exp_rows[r] = '0;
        @(negedge UserCLK);
        Reset = 1'b0;
        @(negedge UserCLK);
        send(SYNC, 0);
        write_frame(3, 7, 32'h5500, 0, ROWS, 1'b1);
        check("t5_latency", 64'(FrameStrobe[67]), 64'd1);

        // 6: back-to-back frames, bits 0 then 319
        write_frame(0, 0, 32'h6000, 0, ROWS, 1'b1);
        write_frame(15, 19, 32'h6100, 0, ROWS, 1'b1);
        check("t6_latency", 64'(FrameStrobe[319]), 64'd1);
        repeat (3) @(negedge UserCLK);
        check("t6_queue_empty", 64'(exp_q.size()), 64'd0);
        check("ready_low_cycles", 64'(ready_low_cnt), 64'(strobes_pushed));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
